// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between a UART loader and a CPU
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_mode,
  input  logic              u_req,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic [DATA_W-1:0] u_wdata,
  output logic              u_ack,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              last_grant,
  output logic [15:0]       u_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

  state_t              r_state, w_state_next;
  logic                r_mem_en, w_mem_en_next;
  logic                r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_din, w_mem_din_next;
  logic                r_u_ack, w_u_ack_next;
  logic                r_c_ack, w_c_ack_next;
  logic [DATA_W-1:0]   r_rdata_hold, w_rdata_hold_next;
  logic                r_last_grant, w_last_grant_next;
  logic [15:0]         r_u_count, w_u_count_next;

  logic                w_u_elig;
  logic                w_c_elig;
  logic                w_pick_c;

  assign w_u_elig = u_req;
  assign w_c_elig = c_req & ~boot_mode;
  // On a tie the requester that did not win last time goes next.
  assign w_pick_c = w_c_elig & (~w_u_elig | ~r_last_grant);

  always_comb begin
    w_state_next      = r_state;
    w_mem_en_next     = 1'b0;
    w_mem_we_next     = 1'b0;
    w_mem_addr_next   = r_mem_addr;
    w_mem_din_next    = r_mem_din;
    w_u_ack_next      = 1'b0;
    w_c_ack_next      = 1'b0;
    w_rdata_hold_next = r_rdata_hold;
    w_last_grant_next = r_last_grant;
    w_u_count_next    = r_u_count;

    case (r_state)
      IDLE: begin
        if (w_u_elig || w_c_elig) begin
          w_state_next      = ACCESS;
          w_mem_en_next     = 1'b1;
          w_last_grant_next = w_pick_c;
          if (w_pick_c) begin
            w_mem_we_next   = c_we;
            w_mem_addr_next = c_addr;
            w_mem_din_next  = c_wdata;
            w_c_ack_next    = c_we;
          end else begin
            w_mem_we_next   = 1'b1;
            w_mem_addr_next = u_addr;
            w_mem_din_next  = u_wdata;
            w_u_ack_next    = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (r_u_ack && (r_u_count != C_COUNT_MAX)) begin
          w_u_count_next = r_u_count + 16'd1;
        end
        // Only CPU reads leave mem_we low, so it doubles as the read flag.
        if (r_mem_we) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = RDATA;
          w_c_ack_next = 1'b1;
        end
      end
      RDATA: begin
        w_rdata_hold_next = mem_dout;
        w_state_next      = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_u_ack      <= 1'b0;
      r_c_ack      <= 1'b0;
      r_rdata_hold <= '0;
      r_last_grant <= 1'b1;
      r_u_count    <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_mem_en     <= w_mem_en_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_din    <= w_mem_din_next;
      r_u_ack      <= w_u_ack_next;
      r_c_ack      <= w_c_ack_next;
      r_rdata_hold <= w_rdata_hold_next;
      r_last_grant <= w_last_grant_next;
      r_u_count    <= w_u_count_next;
    end
  end

  // Read data is presented straight from memory in RDATA and held afterwards.
  assign c_rdata    = (r_state == RDATA) ? mem_dout : r_rdata_hold;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign u_ack      = r_u_ack;
  assign c_ack      = r_c_ack;
  assign busy       = (r_state != IDLE);
  assign last_grant = r_last_grant;
  assign u_count    = r_u_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              boot_mode = 1'b0;
  logic              u_req     = 1'b0;
  logic [ADDR_W-1:0] u_addr    = '0;
  logic [DATA_W-1:0] u_wdata   = '0;
  logic              c_req     = 1'b0;
  logic              c_we      = 1'b0;
  logic [ADDR_W-1:0] c_addr    = '0;
  logic [DATA_W-1:0] c_wdata   = '0;
  logic [DATA_W-1:0] mem_dout  = '0;
  logic              u_ack, c_ack, mem_en, mem_we, busy, last_grant;
  logic [DATA_W-1:0] c_rdata, mem_din;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       u_count;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode),
    .u_req(u_req), .u_addr(u_addr), .u_wdata(u_wdata), .u_ack(u_ack),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .last_grant(last_grant), .u_count(u_count)
  );

  function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Synchronous RAM seen by the DUT: data valid one cycle after the access.
  logic [31:0] env_mem [64];
  logic [63:0] env_vld = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr[5:0]] <= mem_din;
        env_vld[mem_addr[5:0]] <= 1'b1;
      end else begin
        mem_dout <= env_vld[mem_addr[5:0]] ? env_mem[mem_addr[5:0]] : pat(mem_addr);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: phase 0 = nothing in flight, 1 = access cycle, 2 = read return.
  int                m_phase = 0;
  logic              m_we    = 1'b0;
  logic [31:0]       m_mem [int];
  logic              e_en = 0, e_we = 0, e_uack = 0, e_cack = 0, e_last = 1;
  logic [ADDR_W-1:0] e_addr   = '0;
  logic [DATA_W-1:0] e_din    = '0;
  logic [DATA_W-1:0] e_rdata  = '0;
  logic [15:0]       e_ucount = '0;

  logic auto_en = 1'b0;
  logic u_drop = 1'b0, c_drop = 1'b0;
  int   u_rate = 30, c_rate = 30;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [ADDR_W-1:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : pat(a);
  endfunction

  task automatic model_step();
    logic pick_c;
    if (!rst_n) begin
      m_phase = 0; e_en = 0; e_we = 0; e_uack = 0; e_cack = 0; e_last = 1;
      e_addr = '0; e_din = '0; e_rdata = '0; e_ucount = '0;
    end else if (m_phase == 0) begin
      if (u_req || (c_req && !boot_mode)) begin
        pick_c = (c_req && !boot_mode) && (!u_req || (e_last == 1'b0));
        m_we   = pick_c ? c_we : 1'b1;
        e_addr = pick_c ? c_addr : u_addr;
        e_din  = pick_c ? c_wdata : u_wdata;
        e_en   = 1; e_we = m_we;
        e_uack = !pick_c; e_cack = pick_c && c_we;
        e_last = pick_c;
        if (m_we) m_mem[int'(e_addr)] = e_din;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (e_uack && e_ucount != 16'hFFFF) e_ucount = e_ucount + 16'd1;
      e_en = 0; e_we = 0; e_uack = 0;
      if (m_we) begin
        e_cack = 0; m_phase = 0;
      end else begin
        e_cack = 1; e_rdata = mread(e_addr); m_phase = 2;
      end
    end else begin
      e_cack = 0; m_phase = 0;
    end
  endtask

  task automatic compare_all();
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_din", mem_din, e_din);
    check("u_ack", 32'(u_ack), 32'(e_uack));
    check("c_ack", 32'(c_ack), 32'(e_cack));
    check("c_rdata", c_rdata, e_rdata);
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("last_grant", 32'(last_grant), 32'(e_last));
    check("u_count", 32'(u_count), 32'(e_ucount));
  endtask

  // Requesters obey the handshake: hold until ack, drop the cycle after.
  task automatic drive();
    rst_n = ($urandom_range(0, 599) != 0);
    if ($urandom_range(0, 79) == 0) boot_mode = ~boot_mode;
    if (!rst_n) begin
      u_req = 0; u_drop = 0; c_req = 0; c_drop = 0;
    end else begin
      if (u_drop) begin
        u_req = 0; u_drop = 0;
      end else if (u_req && u_ack) begin
        u_drop = 1;
      end else if (!u_req && $urandom_range(0, 99) < u_rate) begin
        u_req = 1; u_addr = ADDR_W'($urandom_range(0, 15)); u_wdata = $urandom();
      end
      if (c_drop) begin
        c_req = 0; c_drop = 0;
      end else if (c_req && c_ack) begin
        c_drop = 1;
      end else if (!c_req && $urandom_range(0, 99) < c_rate) begin
        c_req = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = ADDR_W'($urandom_range(0, 15)); c_wdata = $urandom();
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (auto_en) drive();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic       bad;
    logic [7:0] seq;
    int         n_g;

    repeat (3) cycle();
    check("rst_last_grant", 32'(last_grant), 32'd1);
    check("rst_u_count", 32'(u_count), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_c_rdata", c_rdata, 32'd0);
    rst_n = 1;
    cycle();

    // UART write in boot mode
    boot_mode = 1; u_req = 1; u_addr = 14'h0004; u_wdata = 32'hDEADBEEF;
    cycle();
    check("boot_wr_en", 32'(mem_en), 32'd1);
    check("boot_wr_we", 32'(mem_we), 32'd1);
    check("boot_wr_addr", 32'(mem_addr), 32'h4);
    check("boot_wr_din", mem_din, 32'hDEADBEEF);
    check("boot_wr_uack", 32'(u_ack), 32'd1);
    u_req = 0;
    cycle();
    check("boot_wr_count", 32'(u_count), 32'd1);

    // CPU blocked by boot mode, served once it falls
    c_req = 1; c_we = 1; c_addr = 14'h0005; c_wdata = 32'hCAFEF00D; bad = 0;
    repeat (20) begin
      cycle();
      if (c_ack || mem_en) bad = 1;
    end
    check("boot_block", 32'(bad), 32'd0);
    boot_mode = 0;
    cycle();
    check("unblock_cack", 32'(c_ack), 32'd1);
    check("unblock_addr", 32'(mem_addr), 32'h5);
    c_req = 0;
    cycle();

    // Load 0x12345678 at 0x10, then read it back on the CPU side
    boot_mode = 1; u_req = 1; u_addr = 14'h0010; u_wdata = 32'h12345678;
    cycle();
    u_req = 0;
    cycle();
    boot_mode = 0; c_req = 1; c_we = 0; c_addr = 14'h0010;
    cycle();
    check("rd_access_we", 32'(mem_we), 32'd0);
    check("rd_access_cack", 32'(c_ack), 32'd0);
    cycle();
    check("rd_cack", 32'(c_ack), 32'd1);
    check("rd_data", c_rdata, 32'h12345678);
    check("rd_mem_en", 32'(mem_en), 32'd0);
    c_req = 0;
    cycle();
    check("rd_hold", c_rdata, 32'h12345678);

    // Reset in the middle of a CPU read
    c_req = 1; c_we = 0; c_addr = 14'h0010;
    cycle();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 0;
    cycle();
    check("mid_rst_cack", 32'(c_ack), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(u_count), 32'd0);
    check("mid_rst_rdata", c_rdata, 32'd0);
    check("mid_rst_last", 32'(last_grant), 32'd1);
    c_req = 0; rst_n = 1;
    cycle();

    // Both requesting continuously: grants must alternate U,C,U,C
    u_req = 1; u_addr = 14'h0007; u_wdata = 32'h0000AAAA;
    c_req = 1; c_we = 1; c_addr = 14'h0008; c_wdata = 32'h0000BBBB;
    seq = '0; n_g = 0;
    repeat (8) begin
      cycle();
      if ((u_ack || c_ack) && n_g < 4) begin
        seq = {seq[5:0], u_ack ? 2'b01 : 2'b10};
        n_g++;
      end
    end
    check("rr_sequence", 32'(seq), 32'h66);
    u_req = 0; c_req = 0;
    repeat (2) cycle();

    // Saturation: preload the counter near the top, then keep writing
    boot_mode = 1;
    force dut.r_u_count = 16'hFFF0;
    e_ucount = 16'hFFF0;
    cycle();
    release dut.r_u_count;
    u_req = 1; u_addr = 14'h0003; u_wdata = 32'h55AA55AA;
    repeat (40) cycle();
    check("sat_count", 32'(u_count), 32'hFFFF);
    u_req = 0;
    repeat (2) cycle();
    boot_mode = 0;

    // Randomized traffic with occasional reset and boot_mode toggles
    auto_en = 1;
    u_rate = 30; c_rate = 30;
    repeat (1000) cycle();
    u_rate = 95; c_rate = 95;
    repeat (1000) cycle();
    u_rate = 10; c_rate = 60;
    repeat (1000) cycle();
    auto_en = 0;
    rst_n = 1; u_req = 0; c_req = 0; boot_mode = 0;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, the word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic acts on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port boot_mode, input, 1; while high, only the UART loader is granted.
REQ-006 The block SHALL have ports u_req (input, 1), u_addr (input, ADDR_W) and u_wdata (input, DATA_W), the UART loader write request.
REQ-007 The block SHALL have port u_ack, output, 1, a one-cycle pulse marking completion of a UART write.
REQ-008 The block SHALL have ports c_req (input, 1), c_we (input, 1), c_addr (input, ADDR_W) and c_wdata (input, DATA_W), the CPU read/write request.
REQ-009 The block SHALL have ports c_ack (output, 1) and c_rdata (output, DATA_W), giving CPU completion and read data.
REQ-010 The block SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W) and mem_din (output, DATA_W), driving the shared memory port.
REQ-011 The block SHALL have port mem_dout, input, DATA_W, the memory read data, valid one cycle after the access cycle.
REQ-012 The block SHALL have ports busy (output, 1), last_grant (output, 1; 0=UART, 1=CPU) and u_count (output, 16), giving status.

Function
REQ-013 The block SHALL use the FSM states IDLE, ACCESS and RDATA, and SHALL hold at most one transaction in flight.
REQ-014 In IDLE with no eligible request, the block SHALL remain in IDLE with mem_en=0.
REQ-015 In IDLE with an eligible request, the block SHALL register winner, address, wdata and we into the mem_* output registers and SHALL enter ACCESS.
REQ-016 Eligibility: u_req SHALL always be eligible; c_req SHALL be eligible only when boot_mode=0.
REQ-017 Arbitration: a single eligible requester SHALL win; when both are eligible, the one not equal to last_grant SHALL win (round-robin).
REQ-018 last_grant SHALL update to the winner in the same edge that enters ACCESS.
REQ-019 In ACCESS, mem_en SHALL be 1; mem_we SHALL be 1 for UART and CPU writes and 0 for CPU reads.
REQ-020 For a write, the block SHALL pulse u_ack or c_ack during the ACCESS cycle and return to IDLE on the next edge; latency from req sampled to ack is 1 cycle.
REQ-021 For a CPU read, ACCESS SHALL go to RDATA.
REQ-022 In RDATA, c_rdata SHALL equal mem_dout, c_ack SHALL be 1 and mem_en SHALL be 0; the next state SHALL be IDLE, for a read latency of 2 cycles.
REQ-023 c_rdata SHALL hold its last read value until the next read completes.
REQ-024 A requester SHALL hold req, addr and data stable until ack, and SHALL deassert req in the cycle after ack; a req still high in IDLE SHALL be treated as a new request.
REQ-025 busy SHALL be 1 in ACCESS and RDATA and 0 in IDLE.
REQ-026 u_count SHALL increment on each u_ack and SHALL saturate at 16'hFFFF.
REQ-027 A boot_mode change during ACCESS or RDATA SHALL NOT abort the in-flight transaction; it SHALL take effect at the next IDLE arbitration.
REQ-028 A CPU request blocked by boot_mode SHALL remain pending and SHALL be served after boot_mode falls.
REQ-029 mem_en, mem_we, u_ack and c_ack SHALL be registered outputs and SHALL be glitch-free.

Reset
REQ-030 When rst_n=0 at a rising edge, the state SHALL become IDLE, even mid-transaction, and any in-flight transaction SHALL be dropped without ack.
REQ-031 Reset values SHALL be: mem_en=0, mem_we=0, mem_addr=0, mem_din=0, u_ack=0, c_ack=0, c_rdata=0, busy=0, u_count=0, last_grant=1, so that UART wins the first tie.

Verification
REQ-032 Scenario: boot_mode=1, u_req with addr=0x0004, wdata=0xDEADBEEF -> next cycle mem_en=1, mem_we=1, mem_addr=0x0004, mem_din=0xDEADBEEF, u_ack=1; u_count=1 afterwards.
REQ-033 Scenario: boot_mode=1, c_req held for 20 cycles -> no c_ack and mem_en stays 0; drop boot_mode -> CPU is granted at the next IDLE and c_ack follows.
REQ-034 Scenario: after reset, u_req and c_req rise together with boot_mode=0 -> UART is granted first, then CPU; with both kept requesting, grants alternate U,C,U,C.
REQ-035 Scenario: CPU read of addr 0x0010 where memory returns 0x12345678 -> mem_we=0 in ACCESS; c_ack=1 and c_rdata=0x12345678 two cycles after sampling.
REQ-036 Scenario: rst_n=0 asserted during ACCESS of a CPU read -> no c_ack, all outputs at reset values on the next cycle, and u_count=0.
REQ-037 Scenario: 65536 UART writes -> u_count=0xFFFF; one further write keeps u_count at 0xFFFF.
